circle_tracker: RTL and testbench
=================================

# circle_tracker

Receive-side monitor for the walking-circle animation on the 7-segment bank. On each sample strobe it decodes the `NUM_OF_DISPLAYS` segment bytes back into circle position, row and direction. It then checks every frame-to-frame transition against the legal walk (step by one display, row flip only at an end display), and counts laps and protocol errors. It is used as an on-chip checker for the circle generator and as a self-check source for board debug.

## Interface
- `NUM_OF_DISPLAYS`, 6: number of 7-segment displays observed (≥2).
- `COL_WIDTH`, `$clog2(NUM_OF_DISPLAYS)`: width of position outputs.
- `CNT_WIDTH`, 8: width of lap and error counters.
- `clk_i`, in, 1: clock; single clock domain.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `sample_i`, in, 1: frame strobe; one cycle high when `seg7_i` holds a new frame (the generator's overflow tick).
- `clear_i`, in, 1: synchronous resync; returns the tracker to ACQUIRE and zeroes the counters.
- `seg7_i`, in, `NUM_OF_DISPLAYS`×8 (packed, display i = bits [8i+7:8i]): segment bytes {dp,g,f,e,d,c,b,a}, active-low.
- `valid_o`, out, 1: the last sampled frame was a legal single-circle frame.
- `pos_o`, out, `COL_WIDTH`: display index of the circle in the last valid frame.
- `row_o`, out, 1: 1 = upper circle, 0 = lower circle.
- `dir_o`, out, 1: 1 = moving toward higher index, 0 = toward index 0; meaningful only while `dir_known_o`=1.
- `dir_known_o`, out, 1: a direction has been established since ACQUIRE.
- `step_o`, out, 1: one-cycle pulse when an accepted move or row flip is registered.
- `lap_cnt_o`, out, `CNT_WIDTH`: number of row flips at display `NUM_OF_DISPLAYS-1`, wraps modulo 2^`CNT_WIDTH`.
- `err_cnt_o`, out, `CNT_WIDTH`: number of rejected frames, saturates at all-ones.
- `locked_o`, out, 1: state is TRACK.
- `fault_o`, out, 1: state is FAULT (sticky).

## Operation
- **Per-display classification.** Each display byte is classified combinationally as exactly one of:
  - BLANK = 8'hFF;
  - UPPER = 8'h9C (segments a, b, f, g lit);
  - LOWER = 8'hA3 (segments c, d, e, g lit);
  - OTHER = any other value.
- **Frame classification.** A frame is VALID if exactly one display is UPPER or LOWER and all others are BLANK; q = that display index, s = 1 for UPPER and 0 for LOWER. Every other frame is INVALID, including an all-blank frame.
- **State machine.** States ACQUIRE (reset state), TRACK and FAULT. The FSM acts only on cycles with `sample_i`=1.
  - **ACQUIRE**
    - VALID: load p←q, r←s, `dir_known_o`←0, go to TRACK.
    - INVALID: remain in ACQUIRE, `err_cnt_o`+1.
  - **TRACK.** The held state is (p, r, d, dir_known). VALID frames are handled by the rules below; an INVALID frame or any VALID (q,s) matching no rule is illegal.
    - Hold: q==p, s==r. No update, no `step_o`.
    - Move up: s==r, q==p+1, and (!dir_known or d==1). Then p←q, d←1, dir_known←1, `step_o`.
    - Move down: s==r, q==p-1, and (!dir_known or d==0). Then p←q, d←0, dir_known←1, `step_o`.
    - Flip at 0: q==p==0, s!=r. Then r←s, d←1, dir_known←1, `step_o`.
    - Flip at top: q==p==`NUM_OF_DISPLAYS`-1, s!=r. Then r←s, d←0, dir_known←1, `step_o`, `lap_cnt_o`+1.
    - Illegal: `err_cnt_o`+1, go to FAULT; p, r and d are not updated.
  - **FAULT**
    - Held outputs keep their last accepted values.
    - `valid_o` still reflects each new sample's classification.
    - INVALID samples increment `err_cnt_o`; VALID samples do not.
    - FAULT is left only via `clear_i` or reset.
- **Output updates.**
  - `valid_o` updates on every sample in every state.
  - `pos_o` and `row_o` follow p and r.
  - `dir_o` follows d.
- **clear_i.** Forces ACQUIRE, zeroes both counters and clears `dir_known_o` and `valid_o`. It has priority over a simultaneous `sample_i`, and that sample is discarded.
- **Width rules.**
  - p±1 is computed in `COL_WIDTH`+1 bits, so that 0-1 and `NUM_OF_DISPLAYS`-1+1 never match a legal q.
  - Indices ≥`NUM_OF_DISPLAYS` cannot occur.

## Timing
- All outputs are registered and update on the rising clock edge where `sample_i`=1; latency is 1 cycle from the sample edge to the outputs.
- `step_o` is high for exactly the cycle after the accepting sample.
- Back-to-back `sample_i` (every cycle) is supported at full rate; no back-pressure.
- Reset value of every output: `valid_o`, `pos_o`, `row_o`, `dir_o`, `dir_known_o`, `step_o`, `lap_cnt_o`, `err_cnt_o`, `locked_o` and `fault_o` are all 0.
- Reset assertion mid-frame returns to ACQUIRE asynchronously.
- `seg7_i` is only required to be stable on the `sample_i` edge.

## Test plan
- **Reset and acquire.** Reset, then sample display 0 = 8'h9C with the rest 8'hFF → `locked_o`=1, `pos_o`=0, `row_o`=1, `dir_known_o`=0, `step_o`=0.
- **Full lap (`NUM_OF_DISPLAYS`=6).** Drive the generator's sequence from reset: a flip at 0 to lower, moves up to 5, a flip at 5 to upper, moves down to 0. Expect 12 `step_o` pulses, `lap_cnt_o`=1, `err_cnt_o`=0, `dir_o` 1 then 0.
- **Skipped display.** In TRACK at p=2, d=1, sample q=4 → `fault_o`=1, `err_cnt_o`=1, `pos_o` stays 2. A further VALID sample leaves `err_cnt_o` at 1.
- **Bad frames.**
  - Two displays lit (8'h9C on both 1 and 3): `valid_o`=0, `err_cnt_o`+1.
  - Byte 8'h00 on one display: `valid_o`=0, `err_cnt_o`+1.
  - All-blank frame in ACQUIRE: `err_cnt_o`+1, stays in ACQUIRE.
- **Illegal reversal and mid-row flip.**
  - In TRACK at p=3, d=1, sample q=2 with the same row → FAULT.
  - After `clear_i`, with p=3, sample q=3 with the row toggled → FAULT.
- **Clear, saturation and async reset.**
  - `clear_i` asserted together with `sample_i` → the sample is ignored and the counters are 0 the next cycle.
  - 300 INVALID samples → `err_cnt_o`=255.
  - `rst_i` pulsed mid-lap → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/circle_tracker.sv
// Receive-side checker for the walking-circle 7-segment animation: decodes each
// sampled frame into circle position/row, validates the walk, counts laps and errors.
module circle_tracker #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = $clog2(NUM_OF_DISPLAYS),
  parameter int CNT_WIDTH       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sample_i,
  input  logic                         clear_i,
  input  logic [NUM_OF_DISPLAYS*8-1:0] seg7_i,
  output logic                         valid_o,
  output logic [COL_WIDTH-1:0]         pos_o,
  output logic                         row_o,
  output logic                         dir_o,
  output logic                         dir_known_o,
  output logic                         step_o,
  output logic [CNT_WIDTH-1:0]         lap_cnt_o,
  output logic [CNT_WIDTH-1:0]         err_cnt_o,
  output logic                         locked_o,
  output logic                         fault_o
);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_UPPER = 8'h9C;
  localparam logic [7:0] SEG_LOWER = 8'hA3;

  localparam logic [COL_WIDTH-1:0] POS_TOP  = COL_WIDTH'(NUM_OF_DISPLAYS - 1);
  localparam logic [COL_WIDTH-1:0] POS_ZERO = '0;
  localparam logic [COL_WIDTH:0]   POS_ONE  = (COL_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [COL_WIDTH-1:0]   p_q, p_d;
  logic                   r_q, r_d;
  logic                   d_q, d_d;
  logic                   dk_q, dk_d;
  logic                   valid_q, valid_d;
  logic                   step_q, step_d;
  logic [CNT_WIDTH-1:0]   lap_q, lap_d;
  logic [CNT_WIDTH-1:0]   err_q, err_d;

  logic [7:0]             byte_v;
  logic                   hit, multi_hit, other_hit, frame_valid;
  logic [COL_WIDTH-1:0]   q;
  logic                   s;
  logic [COL_WIDTH:0]     p_up, p_dn, q_ext;
  logic                   err_inc;

  // Frame decode: exactly one circle byte and every other byte blank.
  always_comb begin
    byte_v    = SEG_BLANK;
    hit       = 1'b0;
    multi_hit = 1'b0;
    other_hit = 1'b0;
    q         = '0;
    s         = 1'b0;
    for (int i = 0; i < NUM_OF_DISPLAYS; i++) begin
      byte_v = seg7_i[8*i +: 8];
      if (byte_v == SEG_UPPER || byte_v == SEG_LOWER) begin
        if (hit) multi_hit = 1'b1;
        hit = 1'b1;
        q   = COL_WIDTH'(i);
        s   = (byte_v == SEG_UPPER);
      end else if (byte_v != SEG_BLANK) begin
        other_hit = 1'b1;
      end
    end
    frame_valid = hit & ~multi_hit & ~other_hit;
  end

  // One extra bit keeps 0-1 and TOP+1 from aliasing onto a real display index.
  assign p_up  = {1'b0, p_q} + POS_ONE;
  assign p_dn  = {1'b0, p_q} - POS_ONE;
  assign q_ext = {1'b0, q};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    r_d     = r_q;
    d_d     = d_q;
    dk_d    = dk_q;
    valid_d = valid_q;
    step_d  = 1'b0;
    lap_d   = lap_q;
    err_d   = err_q;
    err_inc = 1'b0;

    if (clear_i) begin
      state_d = ST_ACQUIRE;
      lap_d   = '0;
      err_d   = '0;
      dk_d    = 1'b0;
      valid_d = 1'b0;
    end else if (sample_i) begin
      valid_d = frame_valid;
      case (state_q)
        ST_ACQUIRE: begin
          if (frame_valid) begin
            p_d     = q;
            r_d     = s;
            dk_d    = 1'b0;
            state_d = ST_TRACK;
          end else begin
            err_inc = 1'b1;
          end
        end
        ST_TRACK: begin
          if (!frame_valid) begin
            err_inc = 1'b1;
            state_d = ST_FAULT;
          end else if (q == p_q && s == r_q) begin
            step_d = 1'b0;
          end else if (s == r_q && q_ext == p_up && (!dk_q || d_q)) begin
            p_d    = q;
            d_d    = 1'b1;
            dk_d   = 1'b1;
            step_d = 1'b1;
          end else if (s == r_q && q_ext == p_dn && (!dk_q || !d_q)) begin
            p_d    = q;
            d_d    = 1'b0;
            dk_d   = 1'b1;
            step_d = 1'b1;
          end else if (s != r_q && q == p_q && p_q == POS_ZERO) begin
            r_d    = s;
            d_d    = 1'b1;
            dk_d   = 1'b1;
            step_d = 1'b1;
          end else if (s != r_q && q == p_q && p_q == POS_TOP) begin
            r_d    = s;
            d_d    = 1'b0;
            dk_d   = 1'b1;
            step_d = 1'b1;
            lap_d  = lap_q + CNT_ONE;
          end else begin
            err_inc = 1'b1;
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (!frame_valid) err_inc = 1'b1;
        end
        default: state_d = ST_ACQUIRE;
      endcase
      if (err_inc && err_q != '1) err_d = err_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_ACQUIRE;
      p_q     <= '0;
      r_q     <= 1'b0;
      d_q     <= 1'b0;
      dk_q    <= 1'b0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      lap_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      r_q     <= r_d;
      d_q     <= d_d;
      dk_q    <= dk_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      lap_q   <= lap_d;
      err_q   <= err_d;
    end
  end

  assign valid_o     = valid_q;
  assign pos_o       = p_q;
  assign row_o       = r_q;
  assign dir_o       = d_q;
  assign dir_known_o = dk_q;
  assign step_o      = step_q;
  assign lap_cnt_o   = lap_q;
  assign err_cnt_o   = err_q;
  assign locked_o    = (state_q == ST_TRACK);
  assign fault_o     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_circle_tracker.sv
// Directed, table-driven bench for circle_tracker with six displays.
module tb_circle_tracker;

  localparam int N  = 6;
  localparam int CW = $clog2(N);
  localparam int KW = 8;

  logic            clk_i;
  logic            rst_i;
  logic            sample_i;
  logic            clear_i;
  logic [N*8-1:0]  seg7_i;
  logic            valid_o;
  logic [CW-1:0]   pos_o;
  logic            row_o;
  logic            dir_o;
  logic            dir_known_o;
  logic            step_o;
  logic [KW-1:0]   lap_cnt_o;
  logic [KW-1:0]   err_cnt_o;
  logic            locked_o;
  logic            fault_o;

  circle_tracker #(.NUM_OF_DISPLAYS(N), .CNT_WIDTH(KW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample_i), .clear_i(clear_i),
    .seg7_i(seg7_i), .valid_o(valid_o), .pos_o(pos_o), .row_o(row_o),
    .dir_o(dir_o), .dir_known_o(dir_known_o), .step_o(step_o),
    .lap_cnt_o(lap_cnt_o), .err_cnt_o(err_cnt_o), .locked_o(locked_o),
    .fault_o(fault_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit             clr;
    bit             smp;
    logic [N*8-1:0] seg;
    int             valid, pos, row, dir, dk, step, lock, fault, lap, err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   steps_seen = 0;

  function automatic logic [N*8-1:0] blank();
    logic [N*8-1:0] f;
    f = '1;
    return f;
  endfunction

  function automatic logic [N*8-1:0] circ(int pos, bit up);
    logic [N*8-1:0] f;
    f = '1;
    f[8*pos +: 8] = up ? 8'h9C : 8'hA3;
    return f;
  endfunction

  task automatic add(bit clr, bit smp, logic [N*8-1:0] seg, int valid, int pos, int row,
                     int dir, int dk, int step, int lock, int fault, int lap, int err);
    vec_t v;
    v.clr = clr; v.smp = smp; v.seg = seg;
    v.valid = valid; v.pos = pos; v.row = row; v.dir = dir; v.dk = dk;
    v.step = step; v.lock = lock; v.fault = fault; v.lap = lap; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(bit clr, bit smp, logic [N*8-1:0] seg);
    clear_i  = clr;
    sample_i = smp;
    seg7_i   = seg;
    @(posedge clk_i);
    #1;
    clear_i  = 1'b0;
    sample_i = 1'b0;
  endtask

  task automatic chk_all(string tag, int valid, int pos, int row, int dir, int dk, int step,
                         int lock, int fault, int lap, int err);
    chk({tag, ".valid"}, int'(valid_o), valid);
    chk({tag, ".pos"},   int'(pos_o), pos);
    chk({tag, ".row"},   int'(row_o), row);
    chk({tag, ".dir"},   int'(dir_o), dir);
    chk({tag, ".dk"},    int'(dir_known_o), dk);
    chk({tag, ".step"},  int'(step_o), step);
    chk({tag, ".lock"},  int'(locked_o), lock);
    chk({tag, ".fault"}, int'(fault_o), fault);
    chk({tag, ".lap"},   int'(lap_cnt_o), lap);
    chk({tag, ".err"},   int'(err_cnt_o), err);
  endtask

  initial begin
    logic [N*8-1:0] f;

    // clr smp seg               valid pos row dir dk step lock fault lap err
    add(0, 1, circ(0, 1),          1, 0, 1, 0, 0, 0, 1, 0, 0, 0);  // acquire
    add(0, 1, circ(0, 1),          1, 0, 1, 0, 0, 0, 1, 0, 0, 0);  // hold
    add(0, 1, circ(0, 0),          1, 0, 0, 1, 1, 1, 1, 0, 0, 0);  // flip at 0
    for (int i = 1; i < N; i++)
      add(0, 1, circ(i, 0),        1, i, 0, 1, 1, 1, 1, 0, 0, 0);  // walk up
    add(0, 1, circ(N-1, 1),        1, N-1, 1, 0, 1, 1, 1, 0, 1, 0); // flip at top
    for (int i = N-2; i >= 0; i--)
      add(0, 1, circ(i, 1),        1, i, 1, 0, 1, 1, 1, 0, 1, 0);  // walk down
    add(0, 1, circ(0, 0),          1, 0, 0, 1, 1, 1, 1, 0, 1, 0);
    add(0, 1, circ(1, 0),          1, 1, 0, 1, 1, 1, 1, 0, 1, 0);
    add(0, 1, circ(2, 0),          1, 2, 0, 1, 1, 1, 1, 0, 1, 0);
    add(0, 1, circ(4, 0),          1, 2, 0, 1, 1, 0, 0, 1, 1, 1);  // skipped display
    add(0, 1, circ(3, 0),          1, 2, 0, 1, 1, 0, 0, 1, 1, 1);  // valid in FAULT
    f = circ(1, 1); f[8*3 +: 8] = 8'h9C;
    add(0, 1, f,                   0, 2, 0, 1, 1, 0, 0, 1, 1, 2);  // two lit
    f = blank(); f[8*2 +: 8] = 8'h00;
    add(0, 1, f,                   0, 2, 0, 1, 1, 0, 0, 1, 1, 3);  // other byte
    add(1, 0, blank(),             0, 2, 0, 1, 0, 0, 0, 0, 0, 0);  // clear
    add(0, 1, blank(),             0, 2, 0, 1, 0, 0, 0, 0, 0, 1);  // blank in ACQUIRE
    add(0, 1, circ(2, 1),          1, 2, 1, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, circ(3, 1),          1, 3, 1, 1, 1, 1, 1, 0, 0, 1);
    add(0, 1, circ(2, 1),          1, 3, 1, 1, 1, 0, 0, 1, 0, 2);  // reversal
    add(1, 1, circ(0, 1),          0, 3, 1, 1, 0, 0, 0, 0, 0, 0);  // clear beats sample
    add(0, 1, circ(3, 1),          1, 3, 1, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, circ(3, 0),          1, 3, 1, 1, 0, 0, 0, 1, 0, 1);  // mid-row flip
    add(1, 0, blank(),             0, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, circ(4, 1),          1, 4, 1, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, circ(3, 1),          1, 3, 1, 0, 1, 1, 1, 0, 0, 0);  // first move down
    add(0, 0, circ(0, 0),          1, 3, 1, 0, 1, 0, 1, 0, 0, 0);  // idle cycle, step drops
    add(0, 1, circ(4, 1),          1, 3, 1, 0, 1, 0, 0, 1, 0, 1);  // reversal upward

    clear_i  = 1'b0;
    sample_i = 1'b0;
    seg7_i   = blank();
    rst_i    = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k].clr, vecs[k].smp, vecs[k].seg);
      if (step_o) steps_seen++;
      chk_all($sformatf("v%0d", k), vecs[k].valid, vecs[k].pos, vecs[k].row, vecs[k].dir,
              vecs[k].dk, vecs[k].step, vecs[k].lock, vecs[k].fault, vecs[k].lap,
              vecs[k].err);
      if (k == 2 + 2*(N-1) + 1) chk("lap_steps", steps_seen, 12);
    end

    // Error counter saturation from ACQUIRE.
    apply(1, 0, blank());
    for (int i = 0; i < 300; i++) begin
      apply(0, 1, blank());
      if (i == 253) chk("err_254", int'(err_cnt_o), 254);
    end
    chk("err_sat", int'(err_cnt_o), 255);
    chk("sat_lock", int'(locked_o), 0);

    // Asynchronous reset mid-lap.
    apply(1, 0, blank());
    apply(0, 1, circ(0, 1));
    apply(0, 1, circ(0, 0));
    apply(0, 1, circ(1, 0));
    chk("pre_rst.pos", int'(pos_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    apply(0, 1, circ(5, 0));
    chk_all("post_rst", 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
